// File: rtl/dtag_nway_if.sv
// dtag_nway_if: lookup, update and flush bus between the DCU pipeline and the N-way tag array
// master: lookup/update/flush requests out, lookup response and flush status in
// slave:  the tag array side of the same signals
interface dtag_nway_if #(
    parameter int WAYS  = 4,
    parameter int TAG_W = 18,
    parameter int IDX_W = 9,
    parameter int WAY_W = 2
);
    logic             lkp_req;
    logic [IDX_W-1:0] lkp_idx;
    logic [TAG_W-1:0] lkp_tag;
    logic             rsp_vld;
    logic [WAYS-1:0]  hit_vec;
    logic             hit;
    logic             multi_hit;
    logic [WAY_W-1:0] victim_way;
    logic [TAG_W-1:0] victim_tag;
    logic             victim_valid;
    logic             victim_dirty;
    logic             upd_we;
    logic [IDX_W-1:0] upd_idx;
    logic [WAY_W-1:0] upd_way;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_valid;
    logic             upd_dirty;
    logic             flush_req;
    logic             flush_busy;
    logic             flush_done;
    modport master (
        output lkp_req, lkp_idx, lkp_tag, upd_we, upd_idx, upd_way, upd_tag, upd_valid, upd_dirty, flush_req,
        input  rsp_vld, hit_vec, hit, multi_hit, victim_way, victim_tag, victim_valid, victim_dirty, flush_busy, flush_done
    );
    modport slave (
        input  lkp_req, lkp_idx, lkp_tag, upd_we, upd_idx, upd_way, upd_tag, upd_valid, upd_dirty, flush_req,
        output rsp_vld, hit_vec, hit, multi_hit, victim_way, victim_tag, victim_valid, victim_dirty, flush_busy, flush_done
    );
endinterface

// File: rtl/dtag_nway.sv
// dtag_nway: N-way data-cache tag array with registered compare, tree-PLRU victim and flush sweep
// clk, reset_l (async, active low); bus: lookup request/response, tag/status update, flush request/status
module dtag_nway #(
    parameter int WAYS  = 4,
    parameter int SETS  = 512,
    parameter int TAG_W = 18,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input logic        clk,
    input logic        reset_l,
    dtag_nway_if.slave bus
);
    typedef enum logic {IDLE, SWEEP} state_t;
    state_t           state, state_nx;
    logic [IDX_W-1:0] cnt, cnt_nx;
    logic [TAG_W-1:0] tag_mem [SETS][WAYS];
    logic [WAYS-1:0]  valid [SETS];
    logic [WAYS-1:0]  dirty [SETS];
    logic [WAYS-2:0]  plru [SETS];
    logic             sweep, last;
    logic [WAYS-1:0]  hv;
    logic [WAY_W-1:0] hit_way, vic_way;
    logic             upd_touch, lkp_touch;
    // Node n has children 2n+1 (left, bit 0) and 2n+2 (right); path nodes are set to point away from w.
    function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] p, input logic [WAY_W-1:0] w);
        logic [WAYS-1:0]  r;
        logic [WAY_W-1:0] t;
        int               n;
        r = {1'b0, p};
        t = w;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            r[WAY_W'(n)] = ~t[WAY_W-1];
            n = 2 * n + 1 + int'(t[WAY_W-1]);
            t = t << 1;
        end
        return r[WAYS-2:0];
    endfunction
    // Lowest invalid way wins; with a full set, follow the PLRU tree from the root.
    function automatic logic [WAY_W-1:0] pick(input logic [WAYS-1:0] v, input logic [WAYS-2:0] p);
        logic [WAYS-1:0]  q;
        logic [WAY_W-1:0] w;
        int               n;
        q = {1'b0, p};
        w = '0;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            w = (w << 1) | WAY_W'(q[WAY_W'(n)]);
            n = 2 * n + 1 + int'(q[WAY_W'(n)]);
        end
        for (int i = WAYS - 1; i >= 0; i--)
            if (!v[i]) w = WAY_W'(i);
        return w;
    endfunction
    assign sweep = state == SWEEP;
    assign last = cnt == IDX_W'(SETS - 1);
    assign bus.flush_busy = sweep;
    always_comb begin
        hv = '0;
        hit_way = '0;
        for (int i = 0; i < WAYS; i++)
            hv[i] = !sweep && valid[bus.lkp_idx][i] && tag_mem[bus.lkp_idx][i] == bus.lkp_tag;
        for (int i = WAYS - 1; i >= 0; i--)
            if (hv[i]) hit_way = WAY_W'(i);
        vic_way = sweep ? '0 : pick(valid[bus.lkp_idx], plru[bus.lkp_idx]);
        upd_touch = bus.upd_we && bus.upd_valid;
        // An update touch to the same set overrides the lookup-hit touch.
        lkp_touch = bus.lkp_req && |hv && !(upd_touch && bus.upd_idx == bus.lkp_idx);
    end
    always_comb begin
        state_nx = sweep ? (last ? IDLE : SWEEP) : (bus.flush_req ? SWEEP : IDLE);
        cnt_nx = sweep ? cnt + IDX_W'(1) : '0;
    end
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
            cnt <= '0;
            bus.flush_done <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            bus.flush_done <= sweep && last;
        end
    end
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                plru[s] <= '0;
            end
        end else if (sweep) begin
            valid[cnt] <= '0;
            dirty[cnt] <= '0;
            plru[cnt] <= '0;
        end else begin
            if (lkp_touch) plru[bus.lkp_idx] <= touch(plru[bus.lkp_idx], hit_way);
            if (bus.upd_we) begin
                valid[bus.upd_idx][bus.upd_way] <= bus.upd_valid;
                dirty[bus.upd_idx][bus.upd_way] <= bus.upd_dirty;
                if (bus.upd_valid) plru[bus.upd_idx] <= touch(plru[bus.upd_idx], bus.upd_way);
            end
        end
    end
    always_ff @(posedge clk)
        if (bus.upd_we && !sweep) tag_mem[bus.upd_idx][bus.upd_way] <= bus.upd_tag;
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            bus.rsp_vld <= 1'b0;
            bus.hit_vec <= '0;
            bus.hit <= 1'b0;
            bus.multi_hit <= 1'b0;
            bus.victim_way <= '0;
            bus.victim_tag <= '0;
            bus.victim_valid <= 1'b0;
            bus.victim_dirty <= 1'b0;
        end else begin
            bus.rsp_vld <= bus.lkp_req;
            if (bus.lkp_req) begin
                bus.hit_vec <= hv;
                bus.hit <= |hv;
                bus.multi_hit <= |(hv & (hv - WAYS'(1)));
                bus.victim_way <= vic_way;
                bus.victim_tag <= tag_mem[bus.lkp_idx][vic_way];
                bus.victim_valid <= !sweep && valid[bus.lkp_idx][vic_way];
                bus.victim_dirty <= !sweep && dirty[bus.lkp_idx][vic_way];
            end
        end
    end
endmodule
